// File: rtl/team_06_delay_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : team_06_delay_mem
// Description : Multi-channel audio delay-line memory controller. Each channel
//               owns a circular buffer of DEPTH_WORDS 32-bit words in SRAM.
//               Recorded samples are packed into a per-channel word buffer and
//               written with one bus write per full word. Searches return the
//               sample `offset` positions behind the newest one, served from
//               the pack buffer, a one-word per-channel read cache, or the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module team_06_delay_mem #(
    parameter int          SAMPLE_W    = 8,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          NUM_CH      = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    localparam int         SPW         = 32 / SAMPLE_W,
    localparam int         PTR_W       = $clog2(DEPTH_WORDS * SPW),
    localparam int         CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,          // synchronous, active low
    input  logic                record,
    input  logic                search,
    input  logic [CW-1:0]       ch_sel,       // must be below NUM_CH
    input  logic [PTR_W-1:0]    offset,
    input  logic [SAMPLE_W-1:0] mic_audio,
    input  logic                bus_busy,
    input  logic [31:0]         bus_rdata,
    output logic [31:0]         bus_wdata,
    output logic [31:0]         bus_addr,
    output logic [3:0]          bus_sel,
    output logic                bus_write,
    output logic                bus_read,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_valid,
    output logic                ready
);

    // ------------------------------------------------------------------------
    // Derived widths: a sample pointer splits into {word, lane}
    // ------------------------------------------------------------------------
    localparam int LANE_W = $clog2(SPW);
    localparam int WORD_W = PTR_W - LANE_W;

    // ------------------------------------------------------------------------
    // Controller states
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WR_REQ = 2'd1,
        S_RD_REQ = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Per-channel storage
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]  r_wptr  [NUM_CH];   // next sample slot to be written
    logic [31:0]       r_pack  [NUM_CH];   // word currently being filled
    logic [31:0]       r_cache [NUM_CH];   // last word read from the bus
    logic [WORD_W-1:0] r_tag   [NUM_CH];   // word index held in r_cache
    logic [NUM_CH-1:0] r_cvalid;

    // ------------------------------------------------------------------------
    // Transaction context, latched when a bus command is accepted
    // ------------------------------------------------------------------------
    logic                r_op_wr;          // 1 = write in flight, 0 = read
    logic [CW-1:0]       r_ch;
    logic [WORD_W-1:0]   r_rword;
    logic [LANE_W-1:0]   r_rlane;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [SAMPLE_W-1:0] r_audio;
    logic                r_avalid;

    // ------------------------------------------------------------------------
    // Selected-channel views and pointer arithmetic
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]    w_wptr_sel;
    logic [31:0]         w_pack_cur;
    logic [31:0]         w_cache_cur;
    logic [WORD_W-1:0]   w_tag_cur;
    logic                w_cvalid_cur;
    logic [WORD_W-1:0]   w_wword;
    logic [LANE_W-1:0]   w_wlane;
    logic [PTR_W-1:0]    w_rptr;
    logic [WORD_W-1:0]   w_rword;
    logic [LANE_W-1:0]   w_rlane;
    logic                w_wr_last;
    logic                w_pack_hit;
    logic                w_cache_hit;
    logic [31:0]         w_wr_addr;
    logic [31:0]         w_rd_addr;

    assign w_wptr_sel   = r_wptr[ch_sel];
    assign w_pack_cur   = r_pack[ch_sel];
    assign w_cache_cur  = r_cache[ch_sel];
    assign w_tag_cur    = r_tag[ch_sel];
    assign w_cvalid_cur = r_cvalid[ch_sel];

    assign w_wword = w_wptr_sel[PTR_W-1:LANE_W];
    assign w_wlane = w_wptr_sel[LANE_W-1:0];

    // Newest sample sits at wptr-1; modular wrap makes large offsets alias.
    assign w_rptr  = w_wptr_sel - PTR_W'(1) - offset;
    assign w_rword = w_rptr[PTR_W-1:LANE_W];
    assign w_rlane = w_rptr[LANE_W-1:0];

    assign w_wr_last   = (w_wlane == LANE_W'(SPW - 1));
    assign w_pack_hit  = (w_rword == w_wword);
    assign w_cache_hit = w_cvalid_cur && (w_tag_cur == w_rword);

    // DEPTH_WORDS is a power of two, so ch*DEPTH_WORDS + word == {ch, word}.
    assign w_wr_addr = BASE_ADDR + (32'({ch_sel, w_wword}) << 2);
    assign w_rd_addr = BASE_ADDR + (32'({ch_sel, w_rword}) << 2);

    // ------------------------------------------------------------------------
    // Lane extraction / insertion
    // ------------------------------------------------------------------------
    logic [SAMPLE_W-1:0] w_pack_lane;
    logic [SAMPLE_W-1:0] w_cache_lane;
    logic [SAMPLE_W-1:0] w_rd_lane;
    logic [31:0]         w_pack_new;

    // Pick the addressed lane out of each word source and merge the new sample.
    always_comb begin
        w_pack_lane  = '0;
        w_cache_lane = '0;
        w_rd_lane    = '0;
        w_pack_new   = w_pack_cur;
        for (int l = 0; l < SPW; l++) begin
            if (w_rlane == LANE_W'(l)) begin
                w_pack_lane  = w_pack_cur[l*SAMPLE_W +: SAMPLE_W];
                w_cache_lane = w_cache_cur[l*SAMPLE_W +: SAMPLE_W];
            end
            if (r_rlane == LANE_W'(l)) begin
                w_rd_lane = bus_rdata[l*SAMPLE_W +: SAMPLE_W];
            end
            if (w_wlane == LANE_W'(l)) begin
                w_pack_new[l*SAMPLE_W +: SAMPLE_W] = mic_audio;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    logic w_acc_rec;
    logic w_acc_search;
    logic w_rd_done;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, command acceptance and bus strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_rec    = 1'b0;
        w_acc_search = 1'b0;
        w_rd_done    = 1'b0;
        bus_write    = 1'b0;
        bus_read     = 1'b0;
        ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                // Record has priority; a simultaneous search is dropped and
                // the requester is expected to present it again.
                if (record) begin
                    w_acc_rec = 1'b1;
                    if (w_wr_last) begin
                        w_state_nxt = S_WR_REQ;
                    end
                end else if (search) begin
                    w_acc_search = 1'b1;
                    if (!w_pack_hit && !w_cache_hit) begin
                        w_state_nxt = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                bus_write   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_RD_REQ: begin
                bus_read    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                bus_write = r_op_wr;
                bus_read  = !r_op_wr;
                if (!bus_busy) begin
                    w_state_nxt = S_IDLE;
                    w_rd_done   = !r_op_wr;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        bus_sel = (bus_write || bus_read) ? 4'hF : 4'h0;
    end

    // ------------------------------------------------------------------------
    // Datapath: pointers, pack buffers, caches, transaction context, result
    // ------------------------------------------------------------------------

    // Update channel state on accepted commands and on read completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i]  <= '0;
                r_pack[i]  <= '0;
                r_cache[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_cvalid <= '0;
            r_op_wr  <= 1'b0;
            r_ch     <= '0;
            r_rword  <= '0;
            r_rlane  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_audio  <= '0;
            r_avalid <= 1'b0;
        end else begin
            r_avalid <= 1'b0;

            if (w_acc_rec) begin
                r_pack[ch_sel] <= w_pack_new;
                r_wptr[ch_sel] <= w_wptr_sel + PTR_W'(1);
                if (w_wr_last) begin
                    r_op_wr <= 1'b1;
                    r_ch    <= ch_sel;
                    r_wdata <= w_pack_new;
                    r_addr  <= w_wr_addr;
                    // The SRAM copy of this word is about to change, so a
                    // cached copy of it would go stale.
                    if (w_cvalid_cur && (w_tag_cur == w_wword)) begin
                        r_cvalid[ch_sel] <= 1'b0;
                    end
                end
            end

            if (w_acc_search) begin
                if (w_pack_hit) begin
                    r_audio  <= w_pack_lane;
                    r_avalid <= 1'b1;
                end else if (w_cache_hit) begin
                    r_audio  <= w_cache_lane;
                    r_avalid <= 1'b1;
                end else begin
                    r_op_wr <= 1'b0;
                    r_ch    <= ch_sel;
                    r_rword <= w_rword;
                    r_rlane <= w_rlane;
                    r_addr  <= w_rd_addr;
                end
            end

            if (w_rd_done) begin
                r_cache[r_ch]  <= bus_rdata;
                r_tag[r_ch]    <= r_rword;
                r_cvalid[r_ch] <= 1'b1;
                r_audio        <= w_rd_lane;
                r_avalid       <= 1'b1;
            end
        end
    end

    assign bus_wdata   = r_wdata;
    assign bus_addr    = r_addr;
    assign audio_out   = r_audio;
    assign audio_valid = r_avalid;

endmodule
`default_nettype wire

// File: tb/tb_team_06_delay_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_team_06_delay_mem
// Description : Scoreboard bench for team_06_delay_mem. Two instances: 8-bit
//               samples (16 words/channel) and 16-bit samples (8 words/channel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_team_06_delay_mem;

    localparam int K_WR     = 0;
    localparam int K_RD     = 1;
    localparam int K_AU     = 2;
    localparam int K_BADSEL = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: 8-bit samples, 16 words, 2 channels
    logic        a_record, a_search, a_ch, a_busy;
    logic [5:0]  a_off;
    logic [7:0]  a_mic, a_audio;
    logic [31:0] a_rdata, a_wdata, a_addr;
    logic [3:0]  a_sel;
    logic        a_write, a_read, a_avalid, a_ready;

    // instance B: 16-bit samples, 8 words, 2 channels
    logic        b_record, b_search, b_ch, b_busy;
    logic [3:0]  b_off;
    logic [15:0] b_mic, b_audio;
    logic [31:0] b_rdata, b_wdata, b_addr;
    logic [3:0]  b_sel;
    logic        b_write, b_read, b_avalid, b_ready;

    team_06_delay_mem #(.SAMPLE_W(8), .DEPTH_WORDS(16), .NUM_CH(2), .BASE_ADDR(32'h3300_0000)) u_dut_a (
        .clk(clk), .rst(rst), .record(a_record), .search(a_search), .ch_sel(a_ch),
        .offset(a_off), .mic_audio(a_mic), .bus_busy(a_busy), .bus_rdata(a_rdata),
        .bus_wdata(a_wdata), .bus_addr(a_addr), .bus_sel(a_sel), .bus_write(a_write),
        .bus_read(a_read), .audio_out(a_audio), .audio_valid(a_avalid), .ready(a_ready)
    );

    team_06_delay_mem #(.SAMPLE_W(16), .DEPTH_WORDS(8), .NUM_CH(2), .BASE_ADDR(32'h3300_0000)) u_dut_b (
        .clk(clk), .rst(rst), .record(b_record), .search(b_search), .ch_sel(b_ch),
        .offset(b_off), .mic_audio(b_mic), .bus_busy(b_busy), .bus_rdata(b_rdata),
        .bus_wdata(b_wdata), .bus_addr(b_addr), .bus_sel(b_sel), .bus_write(b_write),
        .bus_read(b_read), .audio_out(b_audio), .audio_valid(b_avalid), .ready(b_ready)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic void push(int d, int k, logic [31:0] a, logic [31:0] dt);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = dt;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void check_ev(int d, int k, logic [31:0] a, logic [31:0] dt);
        ev_t e;
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL dut%0d_event got kind=%0d addr=%h data=%h required none", d, k, a, dt);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.kind != k || e.addr !== a || e.data !== dt) begin
            failures++;
            $display("FAIL dut%0d_event got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                     d, k, a, dt, e.kind, e.addr, e.data);
        end
    endfunction

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endfunction

    // Monitor: every new strobe and every audio_valid pulse is one scoreboard event.
    logic a_pw = 1'b0, a_pr = 1'b0, b_pw = 1'b0, b_pr = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (a_write && !a_pw) check_ev(0, (a_sel == 4'hF) ? K_WR : K_BADSEL, a_addr, a_wdata);
            if (a_read  && !a_pr) check_ev(0, (a_sel == 4'hF) ? K_RD : K_BADSEL, a_addr, 32'h0);
            if (a_avalid)         check_ev(0, K_AU, 32'h0, 32'(a_audio));
            if (b_write && !b_pw) check_ev(1, (b_sel == 4'hF) ? K_WR : K_BADSEL, b_addr, b_wdata);
            if (b_read  && !b_pr) check_ev(1, (b_sel == 4'hF) ? K_RD : K_BADSEL, b_addr, 32'h0);
            if (b_avalid)         check_ev(1, K_AU, 32'h0, 32'(b_audio));
        end
        a_pw <= a_write;
        a_pr <= a_read;
        b_pw <= b_write;
        b_pr <= b_read;
    end

    // SRAM responders: busy for 3 cycles after a strobe is seen, then release for one.
    initial begin
        a_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (a_write || a_read) begin
                repeat (3) @(negedge clk);
                a_busy = 1'b0;
                @(negedge clk);
                a_busy = 1'b1;
            end
        end
    end

    initial begin
        b_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (b_write || b_read) begin
                repeat (3) @(negedge clk);
                b_busy = 1'b0;
                @(negedge clk);
                b_busy = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic a_wait_ready();
        int n = 0;
        while (a_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (a_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL a_ready_timeout got=%b required=1", a_ready);
        end
    endtask

    task automatic b_wait_ready();
        int n = 0;
        while (b_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (b_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL b_ready_timeout got=%b required=1", b_ready);
        end
    endtask

    task automatic a_rec(input logic ch, input logic [7:0] s);
        a_wait_ready();
        a_record = 1'b1; a_ch = ch; a_mic = s;
        @(negedge clk);
        a_record = 1'b0;
    endtask

    task automatic a_srch(input logic ch, input logic [5:0] off);
        a_wait_ready();
        a_search = 1'b1; a_ch = ch; a_off = off;
        @(negedge clk);
        a_search = 1'b0;
    endtask

    task automatic b_rec(input logic ch, input logic [15:0] s);
        b_wait_ready();
        b_record = 1'b1; b_ch = ch; b_mic = s;
        @(negedge clk);
        b_record = 1'b0;
    endtask

    task automatic b_srch(input logic ch, input logic [3:0] off);
        b_wait_ready();
        b_search = 1'b1; b_ch = ch; b_off = off;
        @(negedge clk);
        b_search = 1'b0;
    endtask

    initial begin
        logic [31:0] wd;
        logic [31:0] wa;
        int          n;
        ev_t         e;

        a_record = 0; a_search = 0; a_ch = 0; a_off = 0; a_mic = 0; a_rdata = 0;
        b_record = 0; b_search = 0; b_ch = 0; b_off = 0; b_mic = 0; b_rdata = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ready",  32'(a_ready),  32'h1);
        chk("rst_write",  32'(a_write),  32'h0);
        chk("rst_read",   32'(a_read),   32'h0);
        chk("rst_sel",    32'(a_sel),    32'h0);
        chk("rst_addr",   a_addr,        32'h0);
        chk("rst_wdata",  a_wdata,       32'h0);
        chk("rst_audio",  32'(a_audio),  32'h0);
        chk("rst_avalid", 32'(a_avalid), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // 1: four samples pack into one write; ready returns one cycle after busy release
        push(0, K_WR, 32'h3300_0000, 32'h4433_2211);
        a_rec(0, 8'h11); a_rec(0, 8'h22); a_rec(0, 8'h33);
        chk("t1_ready_partial", 32'(a_ready), 32'h1);
        a_rec(0, 8'h44);
        chk("t1_ready_req", 32'(a_ready), 32'h0);
        chk("t1_write_req", 32'(a_write), 32'h1);
        repeat (3) @(negedge clk);
        chk("t1_ready_wait", 32'(a_ready), 32'h0);
        @(negedge clk);
        chk("t1_ready_back", 32'(a_ready), 32'h1);

        // 2: bypass from pack buffer, then a bus read
        a_rec(0, 8'h55);
        push(0, K_AU, 32'h0, 32'h55);
        a_srch(0, 6'd0);
        chk("t2_bypass_valid", 32'(a_avalid), 32'h1);
        chk("t2_bypass_read",  32'(a_read),   32'h0);
        a_rdata = 32'h4433_2211;
        push(0, K_RD, 32'h3300_0000, 32'h0);
        push(0, K_AU, 32'h0, 32'h44);
        a_srch(0, 6'd1);
        chk("t2_read_issued", 32'(a_read), 32'h1);
        a_wait_ready();
        chk("t2_valid_at_idle", 32'(a_avalid), 32'h1);

        // 3: cache hit on the word just read
        push(0, K_AU, 32'h0, 32'h33);
        a_srch(0, 6'd2);
        chk("t3_hit_valid", 32'(a_avalid), 32'h1);
        chk("t3_hit_read",  32'(a_read),   32'h0);
        push(0, K_WR, 32'h3300_0004, 32'h8877_6655);
        a_rec(0, 8'h66); a_rec(0, 8'h77); a_rec(0, 8'h88);
        a_rdata = 32'h8877_6655;
        push(0, K_RD, 32'h3300_0004, 32'h0);
        push(0, K_AU, 32'h0, 32'h88);
        a_srch(0, 6'd0);

        // 4: channel 1 writes at its own base; channel 0 state untouched
        push(0, K_WR, 32'h3300_0040, 32'hD4C3_B2A1);
        a_rec(1, 8'hA1); a_rec(1, 8'hB2); a_rec(1, 8'hC3); a_rec(1, 8'hD4);
        push(0, K_AU, 32'h0, 32'h88);
        a_srch(0, 6'd0);
        chk("t4_ch0_cache_hit", 32'(a_read), 32'h0);

        // 5a: record and search together -> only the record is taken
        a_wait_ready();
        a_record = 1'b1; a_search = 1'b1; a_ch = 1'b0; a_mic = 8'h99; a_off = 6'd0;
        @(negedge clk);
        a_record = 1'b0; a_search = 1'b0;
        chk("t5_both_avalid", 32'(a_avalid), 32'h0);
        chk("t5_both_ready",  32'(a_ready),  32'h1);
        push(0, K_AU, 32'h0, 32'h99);
        a_srch(0, 6'd0);

        // 5b: record through a full wrap; word 0 comes back at the channel base
        for (int k = 9; k < 72; k++) begin
            if (k % 4 == 3) begin
                wd = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
                if (k == 11) wd[7:0] = 8'h99;
                wa = 32'h3300_0000 + 32'(((k / 4) % 16) * 4);
                push(0, K_WR, wa, wd);
            end
            a_rec(0, 8'(k));
        end
        a_wait_ready();
        // word 1 was rewritten, so its cached copy must not be used
        a_rdata = 32'h4746_4544;
        push(0, K_RD, 32'h3300_0004, 32'h0);
        push(0, K_AU, 32'h0, 32'h47);
        a_srch(0, 6'd0);
        a_wait_ready();

        // 6a: reset while waiting on the bus abandons the read
        push(0, K_RD, 32'h3300_007C, 32'h0);
        a_srch(1, 6'd5);
        chk("t6_read_issued", 32'(a_read), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_read",   32'(a_read),   32'h0);
        chk("t6_rst_write",  32'(a_write),  32'h0);
        chk("t6_rst_ready",  32'(a_ready),  32'h1);
        chk("t6_rst_avalid", 32'(a_avalid), 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        // pointers and caches were cleared: newest-sample search misses to word 15
        a_rdata = 32'hDEAD_BEEF;
        push(0, K_RD, 32'h3300_003C, 32'h0);
        push(0, K_AU, 32'h0, 32'hDE);
        a_srch(0, 6'd0);
        a_wait_ready();

        // 6b: 16-bit samples pack as {s1, s0}
        b_rec(0, 16'h1234);
        push(1, K_WR, 32'h3300_0000, 32'hABCD_1234);
        b_rec(0, 16'hABCD);
        b_rec(0, 16'h5A5A);
        b_rdata = 32'hABCD_1234;
        push(1, K_RD, 32'h3300_0000, 32'h0);
        push(1, K_AU, 32'h0, 32'hABCD);
        b_srch(0, 4'd1);
        push(1, K_AU, 32'h0, 32'h1234);
        b_srch(0, 4'd2);
        push(1, K_AU, 32'h0, 32'h5A5A);
        b_srch(0, 4'd0);
        b_rec(1, 16'h0001);
        push(1, K_WR, 32'h3300_0020, 32'h0002_0001);
        b_rec(1, 16'h0002);
        b_wait_ready();

        // drain the scoreboard
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (q0.size() != 0) begin
            e = q0.pop_front();
            checks++;
            failures++;
            $display("FAIL dut0_missing got=none required kind=%0d addr=%h data=%h", e.kind, e.addr, e.data);
        end
        while (q1.size() != 0) begin
            e = q1.pop_front();
            checks++;
            failures++;
            $display("FAIL dut1_missing got=none required kind=%0d addr=%h data=%h", e.kind, e.addr, e.data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
